rsa_decrypt_ct: RTL and testbench

RSA_DECRYPT_CT -- requirements
Module: rsa_decrypt_ct

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_decrypt_ct_modmul.sv | 63 ++++++
 rtl/rsa_decrypt_ct.sv | 135 +++++++++++++
 tb/tb_rsa_decrypt_ct.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared FSM encoding and latency formula for the RSA decrypt block
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_FIN  = 3'd4
    } rsa_state_e;

    function automatic int rsa_lat(input int w);
        return 2 * w * (w + 2) + 2;
    endfunction

endpackage

// File: rtl/rsa_decrypt_ct_modmul.sv
// rtl/rsa_decrypt_ct_modmul.sv - bit-serial interleaved modular multiplier, fixed WIDTH+2 cycle latency
module modmul_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             rdy
);
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;

    logic [AW-1:0] sum, sub1, sub2, n1, n2, acc_d;

    // Both reductions are always evaluated so timing and activity do not depend on data.
    always_comb begin
        n1    = {2'b00, n_q};
        n2    = {1'b0, n_q, 1'b0};
        sum   = (acc_q << 1) + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
        sub1  = sum - n1;
        sub2  = sum - n2;
        acc_d = (sum >= n2) ? sub2 : ((sum >= n1) ? sub1 : sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (go) begin
            a_q      <= a;
            b_q      <= b;
            n_q      <= n;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                acc_q <= acc_d;
                b_q   <= b_q << 1;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign rdy = active_q && (cnt_q == '0);
    assign p   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_decrypt_ct.sv
// rtl/rsa_decrypt_ct.sv - constant-time RSA decryption m = c^d mod n, square-and-multiply-always
module rsa_decrypt_ct
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_out,
    output logic             err
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, dsh_q, dsh_d, n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d, t_q, t_d, m_q, m_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             go_q, go_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [WIDTH-1:0] mm_b, mm_p;
    logic             mm_rdy, bad;

    assign mm_b = (state_q == ST_MUL) ? c_q : r_q;
    assign bad  = (n_q < WIDTH'(2)) || (c_q >= n_q);

    modmul_serial #(.WIDTH(WIDTH)) u_modmul (
        .clk (clk),
        .rst (rst),
        .go  (go_q),
        .a   (r_q),
        .b   (mm_b),
        .n   (n_q),
        .p   (mm_p),
        .rdy (mm_rdy)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        dsh_d   = dsh_q;
        n_d     = n_q;
        r_d     = r_q;
        t_d     = t_q;
        m_d     = m_q;
        bit_d   = bit_q;
        go_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (start) begin
                c_d     = c;
                dsh_d   = d;
                n_d     = n;
                busy_d  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                r_d     = WIDTH'(1);
                t_d     = '0;
                bit_d   = BW'(WIDTH - 1);
                go_d    = 1'b1;
                state_d = ST_SQR;
            end
            ST_SQR: if (mm_rdy) begin
                r_d     = mm_p;
                go_d    = 1'b1;
                state_d = ST_MUL;
            end
            ST_MUL: if (mm_rdy) begin
                // The product is always formed; only the writeback into r follows the exponent bit.
                t_d   = mm_p;
                r_d   = dsh_q[WIDTH-1] ? mm_p : r_q;
                dsh_d = dsh_q << 1;
                if (bit_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    bit_d   = bit_q - 1'b1;
                    go_d    = 1'b1;
                    state_d = ST_SQR;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = bad;
                m_d     = bad ? '0 : r_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            dsh_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            m_q     <= '0;
            bit_q   <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            dsh_q   <= dsh_d;
            n_q     <= n_d;
            r_q     <= r_d;
            t_q     <= t_d;
            m_q     <= m_d;
            bit_q   <= bit_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign m_out = m_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rsa_decrypt_ct.sv
// tb/tb_rsa_decrypt_ct.sv - randomized self-checking bench for rsa_decrypt_ct against a modexp model
module tb_rsa_decrypt_ct;
    localparam int W   = 8;
    localparam int LAT = 162;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] c = '0, d = '0, n = '0;
    logic         busy, done, err;
    logic [W-1:0] m_out;

    int n_chk  = 0;
    int n_pass = 0;

    bit busy_a [0:400];
    bit busy_b [0:400];
    bit busy_tr[0:400];

    always #5 clk = ~clk;

    rsa_decrypt_ct #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .c     (c),
        .d     (d),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .m_out (m_out),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model_exp(input int cv, input int dv, input int nv, output bit e);
        int r;
        e = (nv < 2) || (cv >= nv);
        if (e) return 0;
        r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % nv;
            if ((dv >> i) & 1) r = (r * cv) % nv;
        end
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] cv, input logic [W-1:0] dv, input logic [W-1:0] nv,
                          output int lat, output logic [W-1:0] m, output logic e);
        @(negedge clk);
        c = cv; d = dv; n = nv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = W'($urandom); d = W'($urandom); n = W'($urandom);
        busy_tr[0] = busy;
        lat = -1; m = '0; e = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            busy_tr[k] = busy;
            if (done) begin
                lat = k; m = m_out; e = err;
                break;
            end
        end
        if (lat < 0) check("timeout", 0, 1);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] cv, input logic [W-1:0] dv,
                            input logic [W-1:0] nv);
        int lat, exp_m;
        logic [W-1:0] m;
        logic e;
        bit exp_e;
        exp_m = model_exp(int'(cv), int'(dv), int'(nv), exp_e);
        run_op(cv, dv, nv, lat, m, e);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_m"}, m, exp_m);
        check({tag, "_err"}, e, exp_e);
    endtask

    initial begin
        int lat_a, lat_b, lat, diff, acc_cnt, done_cnt, acc0, acc1;
        logic [W-1:0] m;
        logic e, prev_busy;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m", m_out, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst = 1'b0;

        run_op(81, 103, 143, lat, m, e);
        check("ref_lat", lat, LAT);
        check("ref_m", m, 42);
        check("ref_err", e, 0);
        @(posedge clk); #1;
        check("ref_done_pulse", done, 0);
        check("ref_m_hold", m_out, 42);

        run_op(81, 0, 143, lat, m, e);
        check("d0_lat", lat, LAT);
        check("d0_m", m, 1);
        check("d0_err", e, 0);

        run_op(81, 8'h01, 143, lat_a, m, e);
        for (int k = 0; k <= 400; k++) busy_a[k] = busy_tr[k];
        check("d01_m", m, 81);
        run_op(81, 8'hFF, 143, lat_b, m, e);
        for (int k = 0; k <= 400; k++) busy_b[k] = busy_tr[k];
        check("ct_lat", lat_a, lat_b);
        diff = 0;
        for (int k = 0; k <= LAT; k++) if (busy_a[k] != busy_b[k]) diff++;
        check("ct_busy_wave", diff, 0);
        check("ct_busy_first", busy_a[0], 1);
        check("ct_busy_done", busy_a[LAT], 0);

        op_check("err_c", 200, 103, 143);
        op_check("err_n1", 5, 103, 1);
        op_check("err_n0", 0, 7, 0);
        op_check("edge_c0", 0, 5, 143);
        op_check("edge_cn1", 142, 255, 143);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] nv, cv;
            nv = W'($urandom_range(2, 255));
            cv = (i % 5 == 4) ? W'($urandom) : W'($urandom_range(0, int'(nv) - 1));
            op_check($sformatf("rand%0d", i), cv, W'($urandom), nv);
        end

        @(negedge clk);
        c = 81; d = 103; n = 143; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (49) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_m", m_out, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk) rst = 1'b0;
        run_op(81, 103, 143, lat, m, e);
        check("post_rst_lat", lat, LAT);
        check("post_rst_m", m, 42);
        check("post_rst_err", e, 0);

        @(negedge clk);
        c = 81; d = 103; n = 143; start = 1'b1;
        acc_cnt = 0; done_cnt = 0; acc0 = -1; acc1 = -1; prev_busy = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (k == 200) start = 1'b0;
            @(posedge clk); #1;
            if (busy && !prev_busy) begin
                if (acc_cnt == 0) acc0 = k;
                else if (acc_cnt == 1) acc1 = k;
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                check($sformatf("hold_m%0d", done_cnt), m_out, 42);
                if (acc_cnt == 2 && !start) break;
            end
            prev_busy = busy;
            @(negedge clk);
        end
        check("hold_acc0", acc0, 0);
        check("hold_acc1", acc1, LAT + 1);
        check("hold_accepts", acc_cnt, 2);
        check("hold_dones", done_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
